// File: rtl/div_unit_if.sv
// Start/ready request and valid-pulse result bundle for the multi-cycle divider.
// The requester uses the master modport; the divider uses the slave modport.
interface div_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, A, B,
    input  ready, valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, A, B,
    output ready, valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_unit.sv
// Iterative restoring shift-subtract divider: one quotient bit per cycle, WIDTH+2 cycle issue interval.
// Define DIV_SIGNED_EN to honour is_signed (sign latches and result negators); otherwise all divides are unsigned.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clock,
  input logic       reset,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [5:0]       count;
  logic             ready_q;
  logic             valid_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_by_zero_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_wide;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic             accept;

  assign accept = (state == IDLE) && bus.start;

  // The partial remainder carries one extra bit so the shifted value never loses its MSB.
  assign rem_wide = {rem, dvd[WIDTH-1]};
  assign trial    = rem_wide - {1'b0, dsr};
  assign q_next   = {dvd[WIDTH-2:0], ~trial[WIDTH]};
  assign r_next   = trial[WIDTH] ? rem_wide[WIDTH-1:0] : trial[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_q;
  logic neg_r;

  assign a_neg = bus.is_signed & bus.A[WIDTH-1];
  assign b_neg = bus.is_signed & bus.B[WIDTH-1];
  assign a_mag = a_neg ? -bus.A : bus.A;
  assign b_mag = b_neg ? -bus.B : bus.B;

  always_ff @(posedge clock) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end

  // INT_MIN / -1 needs no special case: negating 0x8000_0000 yields itself.
  assign q_final = neg_q ? -q_next : q_next;
  assign r_final = neg_r ? -r_next : r_next;
`else
  logic unused_is_signed;

  assign unused_is_signed = bus.is_signed;
  assign a_mag   = bus.A;
  assign b_mag   = bus.B;
  assign q_final = q_next;
  assign r_final = r_next;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      dvd           <= '0;
      dsr           <= '0;
      rem           <= '0;
      count         <= '0;
      ready_q       <= 1'b1;
      valid_q       <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd     <= a_mag;
            dsr     <= b_mag;
            rem     <= '0;
            count   <= '0;
            ready_q <= 1'b0;
            if (bus.B == '0) begin
              state         <= DONE;
              valid_q       <= 1'b1;
              quotient_q    <= '1;
              remainder_q   <= bus.A;
              div_by_zero_q <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          dvd   <= q_next;
          rem   <= r_next;
          count <= count + 6'd1;
          if (count == 6'(WIDTH - 1)) begin
            state         <= DONE;
            valid_q       <= 1'b1;
            quotient_q    <= q_final;
            remainder_q   <= r_final;
            div_by_zero_q <= 1'b0;
          end
        end
        DONE: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready       = ready_q;
  assign bus.valid       = valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, results, zero divisor, overflow, busy-ignore, mid-run reset.
// Expected values for signed vectors follow whichever build (DIV_SIGNED_EN or not) is compiled.
module tb_div_unit;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;

  // Results captured by applyStimulus
  int          lat;
  int          pulses;
  logic [31:0] cap_q;
  logic [31:0] cap_r;
  logic        cap_dbz;
  logic        rdy_after;
  logic        rdy_run;
  logic [31:0] rst_q;
  logic [31:0] rst_r;
  logic        rst_rdy;
  logic        rst_valid;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request, watches a fixed 40-cycle window after it, optionally
  // re-pulsing start or pulsing reset at given cycle offsets (0 = never).
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input int inject_at, input int reset_at);
    lat       = -1;
    pulses    = 0;
    rdy_after = 1'b0;
    rdy_run   = 1'b1;
    @(negedge clock);
    bus.A         = a;
    bus.B         = b;
    bus.is_signed = s;
    bus.start     = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'h0000_0001;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 1) rdy_run = bus.ready;
      if (bus.valid) begin
        pulses++;
        if (lat < 0) begin
          lat     = cyc;
          cap_q   = bus.quotient;
          cap_r   = bus.remainder;
          cap_dbz = bus.div_by_zero;
        end
      end
      if (lat > 0 && cyc == lat + 1) rdy_after = bus.ready;
      if (reset_at > 0 && cyc == reset_at + 1) begin
        reset     = 1'b0;
        rst_q     = bus.quotient;
        rst_r     = bus.remainder;
        rst_rdy   = bus.ready;
        rst_valid = bus.valid;
      end
      bus.start = 1'b0;
      if (cyc == inject_at) begin
        bus.A     = 32'd9;
        bus.B     = 32'd3;
        bus.start = 1'b1;
      end
      if (cyc == reset_at) reset = 1'b1;
      @(posedge clock);
      #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic checkNormal(input string tag, input logic [31:0] eq, input logic [31:0] er);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd33);
    checkOutput({tag, "_pulses"}, 32'(pulses), 32'd1);
    checkOutput({tag, "_quotient"}, cap_q, eq);
    checkOutput({tag, "_remainder"}, cap_r, er);
    checkOutput({tag, "_dbz"}, {31'd0, cap_dbz}, 32'd0);
    checkOutput({tag, "_ready_after"}, {31'd0, rdy_after}, 32'd1);
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_ready", {31'd0, bus.ready}, 32'd1);
    checkOutput("rst_valid", {31'd0, bus.valid}, 32'd0);
    checkOutput("rst_quotient", bus.quotient, 32'd0);
    checkOutput("rst_remainder", bus.remainder, 32'd0);
    checkOutput("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);

    $display("[TB] unsigned 100 / 7");
    applyStimulus(32'd100, 32'd7, 1'b0, 0, 0);
    checkOutput("u100_ready_run", {31'd0, rdy_run}, 32'd0);
    checkNormal("u100", 32'd14, 32'd2);

    $display("[TB] -7 / 2 with is_signed=1");
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0);
`ifdef DIV_SIGNED_EN
    checkNormal("s_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
`else
    checkNormal("s_m7_2", 32'h7FFF_FFFC, 32'd1);
`endif

    $display("[TB] 0xFFFFFFF9 / 2 with is_signed=0");
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b0, 0, 0);
    checkNormal("u_m7_2", 32'h7FFF_FFFC, 32'd1);

    $display("[TB] 7 / -2 with is_signed=1");
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 0);
`ifdef DIV_SIGNED_EN
    checkNormal("s_7_m2", 32'hFFFF_FFFD, 32'd1);
`else
    checkNormal("s_7_m2", 32'd0, 32'd7);
`endif

    $display("[TB] divide by zero");
    applyStimulus(32'h1234_5678, 32'd0, 1'b0, 0, 0);
    checkOutput("dz_latency", 32'(lat), 32'd1);
    checkOutput("dz_pulses", 32'(pulses), 32'd1);
    checkOutput("dz_quotient", cap_q, 32'hFFFF_FFFF);
    checkOutput("dz_remainder", cap_r, 32'h1234_5678);
    checkOutput("dz_dbz", {31'd0, cap_dbz}, 32'd1);
    checkOutput("dz_ready_after", {31'd0, rdy_after}, 32'd1);

    $display("[TB] signed divide by zero");
    applyStimulus(32'hFFFF_FFF9, 32'd0, 1'b1, 0, 0);
    checkOutput("sdz_quotient", cap_q, 32'hFFFF_FFFF);
    checkOutput("sdz_remainder", cap_r, 32'hFFFF_FFF9);
    checkOutput("sdz_dbz", {31'd0, cap_dbz}, 32'd1);

    $display("[TB] INT_MIN / -1");
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
`ifdef DIV_SIGNED_EN
    checkNormal("ovf", 32'h8000_0000, 32'd0);
`else
    checkNormal("ovf", 32'd0, 32'h8000_0000);
`endif

    $display("[TB] busy-ignore");
    applyStimulus(32'd50, 32'd5, 1'b0, 10, 0);
    checkNormal("busy", 32'd10, 32'd0);
    checkOutput("busy_hold_q", bus.quotient, 32'd10);
    checkOutput("busy_hold_r", bus.remainder, 32'd0);
    checkOutput("busy_hold_valid", {31'd0, bus.valid}, 32'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(32'hFFFF_FFFF, 32'd3, 1'b0, 0, 15);
    checkOutput("mrst_pulses", 32'(pulses), 32'd0);
    checkOutput("mrst_ready", {31'd0, rst_rdy}, 32'd1);
    checkOutput("mrst_valid", {31'd0, rst_valid}, 32'd0);
    checkOutput("mrst_quotient", rst_q, 32'd0);
    checkOutput("mrst_remainder", rst_r, 32'd0);

    applyStimulus(32'd9, 32'd3, 1'b0, 0, 0);
    checkNormal("after_rst", 32'd3, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
